// File: rtl/rob_if.sv
// rob_if: dispatch, CDB result and retire/flush signals between the pipeline and the ROB.
interface rob_if #(parameter int IW = 4, parameter int XLEN = 32);
  logic            alloc_flag;
  logic [2:0]      alloc_type;
  logic [4:0]      alloc_rd;
  logic [XLEN-1:0] alloc_pc;
  logic            alloc_pred;
  logic [XLEN-1:0] alloc_alt;
  logic [IW-1:0]   new_ROB_idx;
  logic            rob_full;
  logic            ari_val_flag;
  logic [IW-1:0]   ari_val_idx;
  logic [XLEN-1:0] ari_val;
  logic            cmp_val_flag;
  logic [IW-1:0]   cmp_val_idx;
  logic [XLEN-1:0] cmp_val;
  logic            val_flag_LSB;
  logic [IW-1:0]   val_idx_LSB;
  logic [XLEN-1:0] val_LSB;
  logic            commit_flag;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_val;
  logic [IW-1:0]   commit_idx;
  logic            store_commit;
  logic            jp_wrong;
  logic [XLEN-1:0] jp_pc;
  modport master (
    output alloc_flag, alloc_type, alloc_rd, alloc_pc, alloc_pred, alloc_alt,
    output ari_val_flag, ari_val_idx, ari_val, cmp_val_flag, cmp_val_idx, cmp_val,
    output val_flag_LSB, val_idx_LSB, val_LSB,
    input  new_ROB_idx, rob_full, commit_flag, commit_rd, commit_val, commit_idx,
    input  store_commit, jp_wrong, jp_pc
  );
  modport slave (
    input  alloc_flag, alloc_type, alloc_rd, alloc_pc, alloc_pred, alloc_alt,
    input  ari_val_flag, ari_val_idx, ari_val, cmp_val_flag, cmp_val_idx, cmp_val,
    input  val_flag_LSB, val_idx_LSB, val_LSB,
    output new_ROB_idx, rob_full, commit_flag, commit_rd, commit_val, commit_idx,
    output store_commit, jp_wrong, jp_pc
  );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with in-order single retire and branch/JALR mispredict flush.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int IW    = $clog2(DEPTH)
) (
  input logic  clk,
  input logic  rst,
  input logic  rdy,
  rob_if.slave bus
);
  localparam logic [2:0] T_ARI = 3'd0, T_BR = 3'd1, T_JALR = 3'd2, T_LOAD = 3'd3, T_STORE = 3'd4;
  logic [DEPTH-1:0] valid, ready, pred;
  logic [2:0]       kind  [DEPTH];
  logic [4:0]       rd    [DEPTH];
  logic [XLEN-1:0]  pc    [DEPTH];
  logic [XLEN-1:0]  alt   [DEPTH];
  logic [XLEN-1:0]  value [DEPTH];
  logic [IW-1:0]    head, tail;
  logic [IW:0]      count;
  logic             do_alloc, do_commit, wr, mis;
  logic [2:0]       hk;
  logic [XLEN-1:0]  hv, target;
  logic             ari_hit, cmp_hit, lsb_hit;
  assign bus.rob_full    = count == (IW+1)'(DEPTH);
  assign bus.new_ROB_idx = tail;
  always_comb begin
    hk        = kind[head];
    hv        = value[head];
    do_alloc  = rdy & bus.alloc_flag & ~bus.rob_full & ~bus.jp_wrong;
    do_commit = rdy & valid[head] & ready[head];
    wr        = (hk == T_ARI || hk == T_LOAD || hk == T_JALR) && rd[head] != 5'd0;
    mis       = do_commit & ((hk == T_BR && hv[0] != pred[head]) || (hk == T_JALR && hv != alt[head]));
    target    = hk == T_BR ? alt[head] : hv;
    ari_hit   = bus.ari_val_flag & valid[bus.ari_val_idx];
    cmp_hit   = bus.cmp_val_flag & valid[bus.cmp_val_idx];
    lsb_hit   = bus.val_flag_LSB & valid[bus.val_idx_LSB];
  end
  // Later writes win, giving LSB > cmp > ari on a same-index collision.
  always_ff @(posedge clk)
    if (rdy) begin
      if (ari_hit) value[bus.ari_val_idx] <= bus.ari_val;
      if (cmp_hit) value[bus.cmp_val_idx] <= bus.cmp_val;
      if (lsb_hit) value[bus.val_idx_LSB] <= bus.val_LSB;
      if (do_alloc) begin
        kind[tail] <= bus.alloc_type;
        rd[tail]   <= bus.alloc_rd;
        pc[tail]   <= bus.alloc_pc;
        alt[tail]  <= bus.alloc_alt;
        pred[tail] <= bus.alloc_pred;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid            <= '0;
      ready            <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      bus.commit_flag  <= 1'b0;
      bus.commit_rd    <= '0;
      bus.commit_val   <= '0;
      bus.commit_idx   <= '0;
      bus.store_commit <= 1'b0;
      bus.jp_wrong     <= 1'b0;
      bus.jp_pc        <= '0;
    end else if (rdy) begin
      bus.commit_flag  <= do_commit & wr;
      bus.store_commit <= do_commit & (hk == T_STORE);
      bus.jp_wrong     <= mis;
      if (do_commit) begin
        bus.commit_rd  <= rd[head];
        bus.commit_val <= hk == T_JALR ? pc[head] + XLEN'(4) : hv;
        bus.commit_idx <= head;
      end
      if (mis) bus.jp_pc <= target;
      if (ari_hit) ready[bus.ari_val_idx] <= 1'b1;
      if (cmp_hit) ready[bus.cmp_val_idx] <= 1'b1;
      if (lsb_hit) ready[bus.val_idx_LSB] <= 1'b1;
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        ready[tail] <= bus.alloc_type == T_STORE;
        tail        <= tail + IW'(1);
      end
      if (do_commit) begin
        valid[head] <= 1'b0;
        head        <= head + IW'(1);
      end
      count <= count + (IW+1)'(do_alloc) - (IW+1)'(do_commit);
      // A mispredict squashes everything younger, including a same-edge allocation.
      if (mis) begin
        valid <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios plus randomized traffic checked against a program-order queue model.
module tb_rob_commit;
  localparam logic [2:0] ARI = 3'd0, BR = 3'd1, JALR = 3'd2, LOAD = 3'd3, STORE = 3'd4;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  int checks = 0, errors = 0;
  rob_if #(.IW(4), .XLEN(32)) bus();
  rob_commit #(.DEPTH(16), .XLEN(32)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [3:0]  idx;
    logic [31:0] val;
    bit          done;
    int          born;
  } ent_t;
  ent_t pend[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_flag = 0; bus.alloc_type = 0; bus.alloc_rd = 0; bus.alloc_pc = 0;
    bus.alloc_pred = 0; bus.alloc_alt = 0;
    bus.ari_val_flag = 0; bus.ari_val_idx = 0; bus.ari_val = 0;
    bus.cmp_val_flag = 0; bus.cmp_val_idx = 0; bus.cmp_val = 0;
    bus.val_flag_LSB = 0; bus.val_idx_LSB = 0; bus.val_LSB = 0;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1;
    rst = 0;
    #7;
    @(negedge clk);
    rst = 1;
    cyc();
  endtask

  task automatic set_alloc(input logic [2:0] k, input logic [4:0] r, input logic [31:0] p,
                           input logic pr, input logic [31:0] a);
    bus.alloc_flag = 1; bus.alloc_type = k; bus.alloc_rd = r;
    bus.alloc_pc = p; bus.alloc_pred = pr; bus.alloc_alt = a;
  endtask

  task automatic alloc(input logic [2:0] k, input logic [4:0] r, input logic [31:0] p,
                       input logic pr, input logic [31:0] a);
    set_alloc(k, r, p, pr, a);
    cyc();
    bus.alloc_flag = 0;
  endtask

  task automatic set_port(input int port, input logic [3:0] idx, input logic [31:0] v);
    if (port == 0) begin bus.ari_val_flag = 1; bus.ari_val_idx = idx; bus.ari_val = v; end
    else if (port == 1) begin bus.cmp_val_flag = 1; bus.cmp_val_idx = idx; bus.cmp_val = v; end
    else begin bus.val_flag_LSB = 1; bus.val_idx_LSB = idx; bus.val_LSB = v; end
  endtask

  task automatic result(input int port, input logic [3:0] idx, input logic [31:0] v);
    set_port(port, idx, v);
    cyc();
    bus.ari_val_flag = 0; bus.cmp_val_flag = 0; bus.val_flag_LSB = 0;
  endtask

  task automatic test_reset();
    do_reset();
    alloc(ARI, 7, 32'h0, 0, 0);
    alloc(ARI, 8, 32'h4, 0, 0);
    result(0, 0, 32'hdead);
    cyc();
    checks++; if (bus.commit_flag !== 1'b1) begin errors++; $display("FAIL reset_pre_commit: got %b want 1", bus.commit_flag); end
    bus.alloc_flag = 1;
    #3 rst = 0;
    #1;
    checks++;
    if ({bus.commit_flag, bus.commit_rd, bus.commit_val, bus.commit_idx, bus.store_commit, bus.jp_wrong, bus.jp_pc} !== '0) begin
      errors++; $display("FAIL reset_outputs: flag=%b rd=%0d val=%h idx=%0d st=%b jw=%b jpc=%h want all 0",
        bus.commit_flag, bus.commit_rd, bus.commit_val, bus.commit_idx, bus.store_commit, bus.jp_wrong, bus.jp_pc);
    end
    checks++; if (bus.new_ROB_idx !== 4'd0 || bus.rob_full !== 1'b0) begin errors++; $display("FAIL reset_ptr: idx=%0d full=%b want 0/0", bus.new_ROB_idx, bus.rob_full); end
    idle();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.commit_flag !== 1'b0) begin errors++; $display("FAIL reset_no_commit: got %b want 0", bus.commit_flag); end
    end
  endtask

  task automatic test_ari();
    do_reset();
    alloc(ARI, 5, 32'h100, 0, 0);
    checks++; if (bus.new_ROB_idx !== 4'd1) begin errors++; $display("FAIL ari_tail: got %0d want 1", bus.new_ROB_idx); end
    result(0, 0, 32'h1234);
    checks++; if (bus.commit_flag !== 1'b0) begin errors++; $display("FAIL ari_early: got %b want 0", bus.commit_flag); end
    cyc();
    checks++;
    if (bus.commit_flag !== 1 || bus.commit_rd !== 5 || bus.commit_val !== 32'h1234 || bus.commit_idx !== 0) begin
      errors++; $display("FAIL ari_commit: flag=%b rd=%0d val=%h idx=%0d want 1/5/1234/0", bus.commit_flag, bus.commit_rd, bus.commit_val, bus.commit_idx);
    end
    cyc();
    checks++; if (bus.commit_flag !== 1'b0) begin errors++; $display("FAIL ari_pulse: got %b want 0", bus.commit_flag); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc(ARI, 3, 32'h0, 0, 0);
    alloc(ARI, 4, 32'h4, 0, 0);
    result(0, 1, 32'hB);
    cyc();
    checks++; if (bus.commit_flag !== 1'b0) begin errors++; $display("FAIL ooo_wait: got %b want 0", bus.commit_flag); end
    result(1, 0, 32'hA);
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_idx !== 0 || bus.commit_val !== 32'hA || bus.commit_rd !== 3) begin
      errors++; $display("FAIL ooo_first: flag=%b idx=%0d val=%h rd=%0d want 1/0/a/3", bus.commit_flag, bus.commit_idx, bus.commit_val, bus.commit_rd); end
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_idx !== 1 || bus.commit_val !== 32'hB || bus.commit_rd !== 4) begin
      errors++; $display("FAIL ooo_second: flag=%b idx=%0d val=%h rd=%0d want 1/1/b/4", bus.commit_flag, bus.commit_idx, bus.commit_val, bus.commit_rd); end
    cyc();
    checks++; if (bus.commit_flag !== 1'b0) begin errors++; $display("FAIL ooo_done: got %b want 0", bus.commit_flag); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) alloc(ARI, 5'(i + 1), 32'(i * 4), 0, 0);
    checks++; if (bus.rob_full !== 1'b1 || bus.new_ROB_idx !== 4'd0) begin errors++; $display("FAIL full_set: full=%b idx=%0d want 1/0", bus.rob_full, bus.new_ROB_idx); end
    alloc(ARI, 30, 32'h0, 0, 0);
    checks++; if (bus.rob_full !== 1'b1 || bus.new_ROB_idx !== 4'd0) begin errors++; $display("FAIL full_ignore: full=%b idx=%0d want 1/0", bus.rob_full, bus.new_ROB_idx); end
    result(2, 0, 32'h99);
    checks++; if (bus.rob_full !== 1'b1) begin errors++; $display("FAIL full_hold: got %b want 1", bus.rob_full); end
    alloc(ARI, 20, 32'h0, 0, 0);
    checks++; if (bus.commit_flag !== 1 || bus.commit_idx !== 0 || bus.commit_val !== 32'h99 || bus.commit_rd !== 1) begin
      errors++; $display("FAIL full_commit: flag=%b idx=%0d val=%h rd=%0d want 1/0/99/1", bus.commit_flag, bus.commit_idx, bus.commit_val, bus.commit_rd); end
    checks++; if (bus.rob_full !== 1'b0 || bus.new_ROB_idx !== 4'd0) begin errors++; $display("FAIL full_same_cycle: full=%b idx=%0d want 0/0", bus.rob_full, bus.new_ROB_idx); end
    alloc(ARI, 21, 32'h0, 0, 0);
    checks++; if (bus.rob_full !== 1'b1 || bus.new_ROB_idx !== 4'd1) begin errors++; $display("FAIL wrap_alloc: full=%b idx=%0d want 1/1", bus.rob_full, bus.new_ROB_idx); end
    result(0, 1, 32'h77);
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_idx !== 1 || bus.commit_rd !== 2 || bus.commit_val !== 32'h77) begin
      errors++; $display("FAIL wrap_next: flag=%b idx=%0d rd=%0d val=%h want 1/1/2/77", bus.commit_flag, bus.commit_idx, bus.commit_rd, bus.commit_val); end
  endtask

  task automatic test_branch();
    do_reset();
    alloc(BR, 0, 32'h10, 1, 32'h80);
    alloc(ARI, 2, 32'h14, 0, 0);
    alloc(ARI, 3, 32'h18, 0, 0);
    result(0, 1, 32'h55);
    result(1, 0, 32'h0);
    cyc();
    checks++; if (bus.jp_wrong !== 1 || bus.jp_pc !== 32'h80 || bus.commit_flag !== 0) begin
      errors++; $display("FAIL br_flush: jw=%b jpc=%h flag=%b want 1/80/0", bus.jp_wrong, bus.jp_pc, bus.commit_flag); end
    checks++; if (bus.new_ROB_idx !== 4'd0 || bus.rob_full !== 1'b0) begin errors++; $display("FAIL br_ptr: idx=%0d full=%b want 0/0", bus.new_ROB_idx, bus.rob_full); end
    set_alloc(ARI, 9, 32'h20, 0, 0);
    result(0, 2, 32'h66);
    bus.alloc_flag = 0;
    checks++; if (bus.jp_wrong !== 1'b0 || bus.new_ROB_idx !== 4'd0) begin errors++; $display("FAIL br_discard: jw=%b idx=%0d want 0/0", bus.jp_wrong, bus.new_ROB_idx); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (bus.commit_flag !== 1'b0 || bus.jp_wrong !== 1'b0) begin errors++; $display("FAIL br_quiet: flag=%b jw=%b want 0/0", bus.commit_flag, bus.jp_wrong); end
    end
  endtask

  task automatic test_jalr();
    do_reset();
    alloc(JALR, 1, 32'h40, 0, 32'h100);
    result(1, 0, 32'h200);
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_rd !== 1 || bus.commit_val !== 32'h44 || bus.jp_wrong !== 1 || bus.jp_pc !== 32'h200) begin
      errors++; $display("FAIL jalr_wrong: flag=%b rd=%0d val=%h jw=%b jpc=%h want 1/1/44/1/200", bus.commit_flag, bus.commit_rd, bus.commit_val, bus.jp_wrong, bus.jp_pc); end
    cyc();
    alloc(JALR, 6, 32'h100, 0, 32'h300);
    result(1, 0, 32'h300);
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_val !== 32'h104 || bus.jp_wrong !== 0) begin
      errors++; $display("FAIL jalr_ok: flag=%b val=%h jw=%b want 1/104/0", bus.commit_flag, bus.commit_val, bus.jp_wrong); end
  endtask

  task automatic test_collision();
    do_reset();
    alloc(ARI, 10, 32'h0, 0, 0);
    set_port(0, 0, 32'h1);
    set_port(1, 0, 32'h2);
    result(2, 0, 32'h3);
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_val !== 32'h3) begin errors++; $display("FAIL coll_lsb: flag=%b val=%h want 1/3", bus.commit_flag, bus.commit_val); end
    alloc(ARI, 11, 32'h4, 0, 0);
    set_port(0, 1, 32'h4);
    result(1, 1, 32'h5);
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_val !== 32'h5) begin errors++; $display("FAIL coll_cmp: flag=%b val=%h want 1/5", bus.commit_flag, bus.commit_val); end
  endtask

  task automatic test_store_rdy();
    do_reset();
    alloc(STORE, 0, 32'h0, 0, 0);
    cyc();
    checks++; if (bus.store_commit !== 1 || bus.commit_flag !== 0) begin errors++; $display("FAIL store: st=%b flag=%b want 1/0", bus.store_commit, bus.commit_flag); end
    cyc();
    checks++; if (bus.store_commit !== 1'b0) begin errors++; $display("FAIL store_pulse: got %b want 0", bus.store_commit); end
    alloc(ARI, 9, 32'h4, 0, 0);
    result(0, 1, 32'h42);
    rdy = 0;
    set_alloc(ARI, 12, 32'h8, 0, 0);
    cyc();
    cyc();
    bus.alloc_flag = 0;
    checks++; if (bus.commit_flag !== 1'b0 || bus.new_ROB_idx !== 4'd2) begin errors++; $display("FAIL rdy_freeze: flag=%b idx=%0d want 0/2", bus.commit_flag, bus.new_ROB_idx); end
    rdy = 1;
    cyc();
    checks++; if (bus.commit_flag !== 1 || bus.commit_val !== 32'h42 || bus.commit_idx !== 1) begin
      errors++; $display("FAIL rdy_resume: flag=%b val=%h idx=%0d want 1/42/1", bus.commit_flag, bus.commit_val, bus.commit_idx); end
    alloc(ARI, 0, 32'hc, 0, 0);
    result(2, 2, 32'h9);
    cyc();
    checks++; if (bus.commit_flag !== 1'b0) begin errors++; $display("FAIL rd0_silent: got %b want 0", bus.commit_flag); end
  endtask

  task automatic test_random();
    int next_idx = 0;
    ent_t e;
    int cands[$];
    do_reset();
    pend.delete();
    for (int c = 0; c < 1500; c++) begin
      if (bus.commit_flag || bus.store_commit) begin
        checks++;
        if (pend.size() == 0) begin
          errors++; $display("FAIL rnd_spurious: flag=%b st=%b with nothing outstanding", bus.commit_flag, bus.store_commit);
        end else begin
          e = pend.pop_front();
          if (!e.done || (e.kind == STORE ? !(bus.store_commit && !bus.commit_flag)
              : !(bus.commit_flag && !bus.store_commit && bus.commit_rd == e.rd && bus.commit_val == e.val && bus.commit_idx == e.idx))) begin
            errors++; $display("FAIL rnd_commit: flag=%b st=%b rd=%0d val=%h idx=%0d want kind=%0d rd=%0d val=%h idx=%0d done=%b",
              bus.commit_flag, bus.store_commit, bus.commit_rd, bus.commit_val, bus.commit_idx, e.kind, e.rd, e.val, e.idx, e.done);
          end
        end
      end
      checks++; if (bus.rob_full !== (pend.size() == 16)) begin errors++; $display("FAIL rnd_full: got %b want %b", bus.rob_full, pend.size() == 16); end
      checks++; if (bus.new_ROB_idx !== 4'(next_idx)) begin errors++; $display("FAIL rnd_tail: got %0d want %0d", bus.new_ROB_idx, next_idx); end
      idle();
      if (c < 1200 && pend.size() < 16 && $urandom_range(0, 3) != 0) begin
        e.kind = $urandom_range(0, 2) == 0 ? STORE : ($urandom_range(0, 1) ? LOAD : ARI);
        e.rd = 5'($urandom_range(1, 31));
        e.idx = 4'(next_idx);
        e.val = 0;
        e.done = e.kind == STORE;
        e.born = c;
        set_alloc(e.kind, e.rd, $urandom, 0, 0);
        pend.push_back(e);
        next_idx = (next_idx + 1) % 16;
      end
      cands.delete();
      foreach (pend[k]) if (!pend[k].done && pend[k].born < c) cands.push_back(k);
      if (cands.size() > 0 && (c >= 1200 || $urandom_range(0, 2) != 0)) begin
        int j, p1, p2;
        logic [31:0] v1, v2;
        j = cands[$urandom_range(0, cands.size() - 1)];
        p1 = $urandom_range(0, 2);
        v1 = $urandom;
        set_port(p1, pend[j].idx, v1);
        pend[j].val = v1;
        if ($urandom_range(0, 3) == 0) begin
          p2 = (p1 + 1 + $urandom_range(0, 1)) % 3;
          v2 = $urandom;
          set_port(p2, pend[j].idx, v2);
          if (p2 > p1) pend[j].val = v2;
        end
        pend[j].done = 1;
      end
      cyc();
    end
    idle();
    checks++; if (pend.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d entries never retired, want 0", pend.size()); end
  endtask

  initial begin
    idle();
    test_reset();
    test_ari();
    test_out_of_order();
    test_full_wrap();
    test_branch();
    test_jalr();
    test_collision();
    test_store_rdy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
